seg_display_writer: RTL

//   Downstream stage of the decimal counter datapath. Takes the ten 8-bit

---
 rtl/seg_display_writer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg_display_writer.sv
// seg_display_writer: snapshots ten seven-segment codes and writes only the
// changed 32-bit display words to a memory-mapped display, one handshaked
// bus write at a time, with an optional periodic forced full rewrite.
module seg_display_writer #(
    parameter logic [31:0] BASEADDR       = 32'hF000_0010,
    parameter int unsigned REFRESH_PERIOD = 0
) (
    input  logic        wClk,
    input  logic        wReset,
    input  logic [79:0] bCode,
    input  logic        wUpdate,
    input  logic        wWriteAck,
    output logic        wWrite,
    output logic [31:0] bWriteAddr,
    output logic [31:0] bWriteData,
    output logic [3:0]  bWriteMask,
    output logic        wBusy
);

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e      state_q, state_d;
    logic [79:0] shadow_q, shadow_d;
    logic [31:0] written_q [3];
    logic [31:0] written_d [3];
    logic [2:0]  valid_q, valid_d;
    logic [1:0]  sel_q, sel_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] refresh_q, refresh_d;
    logic        refresh_hit;

    logic [31:0] word [3];
    logic [2:0]  dirty;

    assign word[0] = shadow_q[31:0];
    assign word[1] = shadow_q[63:32];
    assign word[2] = {16'h0, shadow_q[79:64]};

    assign refresh_hit = (REFRESH_PERIOD != 0) && (refresh_q == REFRESH_PERIOD - 1);

    // A word is dirty until acknowledged once, or whenever the snapshot moves away from it.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            dirty[k] = ~valid_q[k] | (word[k] != written_q[k]);
        end
    end

    // Next-state: shadow capture, write selection/handshake and refresh invalidation.
    always_comb begin
        state_d   = state_q;
        shadow_d  = wUpdate ? bCode : shadow_q;
        written_d = written_q;
        valid_d   = valid_q;
        sel_d     = sel_q;
        write_d   = write_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;
        refresh_d = (REFRESH_PERIOD == 0 || refresh_hit) ? 32'd0 : refresh_q + 32'd1;

        unique case (state_q)
            StIdle: begin
                if (|dirty) begin
                    write_d = 1'b1;
                    state_d = StWrite;
                    if (dirty[2]) begin
                        sel_d  = 2'd2;
                        addr_d = BASEADDR + 32'd8;
                        data_d = word[2];
                        mask_d = 4'b1100;
                    end else if (dirty[1]) begin
                        sel_d  = 2'd1;
                        addr_d = BASEADDR + 32'd4;
                        data_d = word[1];
                        mask_d = 4'b0000;
                    end else begin
                        sel_d  = 2'd0;
                        addr_d = BASEADDR;
                        data_d = word[0];
                        mask_d = 4'b0000;
                    end
                end
            end
            StWrite: begin
                if (wWriteAck) begin
                    // Record what was actually sent, not the possibly newer shadow.
                    for (int k = 0; k < 3; k++) begin
                        if (sel_q == 2'(k)) begin
                            written_d[k] = data_q;
                            valid_d[k]   = 1'b1;
                        end
                    end
                    write_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Refresh wins over a coincident ack so that word is sent again.
        if (refresh_hit) begin
            valid_d = 3'b000;
        end
    end

    // State register with synchronous reset; reset abandons any pending write.
    always_ff @(posedge wClk) begin
        if (wReset) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            valid_q   <= 3'b000;
            sel_q     <= 2'd0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            refresh_q <= '0;
            for (int k = 0; k < 3; k++) begin
                written_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            written_q <= written_d;
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            refresh_q <= refresh_d;
        end
    end

    assign wWrite     = write_q;
    assign bWriteAddr = addr_q;
    assign bWriteData = data_q;
    assign bWriteMask = mask_q;
    assign wBusy      = (|dirty) | write_q;

endmodule
